// File: rtl/fsqrt_pipe.sv
// Pipelined binary32 square root: segment-tangent table lookup, three stages, valid/ready
// handshake with a single global advance enable, IEEE special cases and an invalid flag.
module fsqrt_pipe #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [31:0] QNan  = 32'h7FC0_0000;
    localparam logic [31:0] PInf  = 32'h7F80_0000;

    // floor(sqrt(midpoint of segment i) * 2^23), via integer sqrt of midpoint * 2^46
    function automatic logic [23:0] seg_sqrt(input int unsigned i);
        logic [47:0] n;
        logic [23:0] root;
        logic [23:0] trial;
        n    = (48'd1 << 46) + (48'(2 * i + 1) << (45 - ADDR_W));
        root = '0;
        for (int b = 23; b >= 0; b--) begin
            trial = root | (24'd1 << b);
            if (48'(trial) * 48'(trial) <= n) root = trial;
        end
        return root;
    endfunction

    logic [22:0] rom_ah [Depth];
    logic [23:0] rom_b  [Depth];

    for (genvar g = 0; g < Depth; g++) begin : g_rom
        localparam logic [23:0] SegA = seg_sqrt(g);
        assign rom_ah[g] = SegA[23:1];
        assign rom_b[g]  = 24'((48'd1 << 46) / 48'(SegA));
    end

    logic              en;
    logic [ADDR_W-1:0] idx;

    logic              v1_q, v1_d;
    logic [31:0]       x1_q, x1_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d;
    logic [22:0]       ah1_q, ah1_d;
    logic [23:0]       b1_q, b1_d;

    logic              v2_q, v2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;
    logic              spec2_q, spec2_d;
    logic [31:0]       spy2_q, spy2_d;
    logic              nv2_q, nv2_d;
    logic [7:0]        e2_q, e2_d;
    logic              even2_q, even2_d;
    logic [23:0]       r2_q, r2_d;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_y_q, out_y_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_nv_q, out_nv_d;

    logic [23:0]       s2_raw, s2_r;
    logic              s2_spec, s2_nv;
    logic [31:0]       s2_y;
    logic [24:0]       s3_rs;
    logic [22:0]       s3_mant;
    logic [31:0]       s3_y;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign idx      = in_x[22 -: ADDR_W];

    // Tangent at segment midpoint; (A>>1) + ({1,m}*B)>>24 stays below 2^24.
    always_comb begin
        s2_raw = {1'b0, ah1_q} + 24'((48'({1'b1, x1_q[22:0]}) * 48'(b1_q)) >> 24);
        // Truncation can land just under 1.0 near m = 0; pin to 1.0 so the hidden bit survives.
        s2_r   = (s2_raw < 24'h80_0000) ? 24'h80_0000 : s2_raw;
        s2_spec = 1'b1;
        s2_nv   = 1'b0;
        s2_y    = '0;
        if (x1_q[30:23] == 8'd0) begin
            s2_y = {x1_q[31], 31'b0};
        end else if (x1_q[30:23] == 8'hFF && x1_q[22:0] != 23'd0) begin
            s2_y  = QNan;
            s2_nv = !x1_q[22];
        end else if (x1_q[31]) begin
            s2_y  = QNan;
            s2_nv = 1'b1;
        end else if (x1_q[30:23] == 8'hFF) begin
            s2_y = PInf;
        end else begin
            s2_spec = 1'b0;
        end
    end

    // Even biased exponent means an odd true exponent: scale the mantissa by sqrt(2).
    always_comb begin
        s3_rs   = 25'((48'(r2_q) * 48'hB5_04F3) >> 23);
        s3_mant = r2_q[22:0];
        if (even2_q) s3_mant = (s3_rs >= 25'h100_0000) ? 23'h7F_FFFF : s3_rs[22:0];
        s3_y    = spec2_q ? spy2_q : {1'b0, e2_q, s3_mant};
    end

    always_comb begin
        v1_d        = v1_q;
        x1_d        = x1_q;
        tag1_d      = tag1_q;
        ah1_d       = ah1_q;
        b1_d        = b1_q;
        v2_d        = v2_q;
        tag2_d      = tag2_q;
        spec2_d     = spec2_q;
        spy2_d      = spy2_q;
        nv2_d       = nv2_q;
        e2_d        = e2_q;
        even2_d     = even2_q;
        r2_d        = r2_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;
        out_nv_d    = out_nv_q;
        if (en) begin
            v1_d        = in_valid;
            x1_d        = in_x;
            tag1_d      = in_tag;
            ah1_d       = rom_ah[idx];
            b1_d        = rom_b[idx];
            v2_d        = v1_q;
            tag2_d      = tag1_q;
            spec2_d     = s2_spec;
            spy2_d      = s2_y;
            nv2_d       = s2_nv;
            e2_d        = 8'((9'(x1_q[30:23]) + 9'd127) >> 1);
            even2_d     = !x1_q[23];
            r2_d        = s2_r;
            out_valid_d = v2_q;
            out_y_d     = s3_y;
            out_tag_d   = tag2_q;
            out_nv_d    = nv2_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q        <= 1'b0;
            x1_q        <= '0;
            tag1_q      <= '0;
            ah1_q       <= '0;
            b1_q        <= '0;
            v2_q        <= 1'b0;
            tag2_q      <= '0;
            spec2_q     <= 1'b0;
            spy2_q      <= '0;
            nv2_q       <= 1'b0;
            e2_q        <= '0;
            even2_q     <= 1'b0;
            r2_q        <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
            out_nv_q    <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            x1_q        <= x1_d;
            tag1_q      <= tag1_d;
            ah1_q       <= ah1_d;
            b1_q        <= b1_d;
            v2_q        <= v2_d;
            tag2_q      <= tag2_d;
            spec2_q     <= spec2_d;
            spy2_q      <= spy2_d;
            nv2_q       <= nv2_d;
            e2_q        <= e2_d;
            even2_q     <= even2_d;
            r2_q        <= r2_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
            out_nv_q    <= out_nv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;
    assign out_nv    = out_nv_q;

endmodule

// File: tb/tb_fsqrt_pipe.sv
// Scoreboard bench for fsqrt_pipe: directed specials, latency, stall and reset cases,
// then a randomized sweep against an arithmetic reference model.
module tb_fsqrt_pipe;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_nv;

    typedef struct {
        logic [31:0]      x;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             nv;
        bit               normal;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   ready_rand = 1'b0;
    logic ready_fixed = 1'b1;

    fsqrt_pipe #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_nv    (out_nv)
    );

    always #5 clk = ~clk;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
        end
    end

    function automatic longint isqrt_ref(input longint n);
        longint r;
        r = longint'($floor($sqrt(real'(n))));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Tangent-at-midpoint approximation evaluated with plain integer arithmetic.
    function automatic void ref_sqrt(input logic [31:0] x, output logic [31:0] y,
                                     output logic nv, output bit normal);
        longint e, m, i, a, b, r;
        e = longint'(x[30:23]);
        m = longint'(x[22:0]);
        normal = 1'b0;
        nv = 1'b0;
        y = '0;
        if (e == 0) begin
            y = {x[31], 31'b0};
        end else if (e == 255 && m != 0) begin
            y = 32'h7FC0_0000;
            nv = !x[22];
        end else if (x[31]) begin
            y = 32'h7FC0_0000;
            nv = 1'b1;
        end else if (e == 255) begin
            y = 32'h7F80_0000;
        end else begin
            i = m >> (23 - ADDR_W);
            a = isqrt_ref((64'sd1 << 46) + (2 * i + 1) * (64'sd1 << (45 - ADDR_W)));
            b = (64'sd1 << 46) / a;
            r = a / 2 + ((64'sd8388608 + m) * b) / 64'sd16777216;
            if (r < 64'sd8388608) r = 64'sd8388608;
            if (e % 2 == 0) r = (r * 64'sd11863283) / 64'sd8388608;
            if (r > 64'sd16777215) r = 64'sd16777215;
            y = {1'b0, 8'((e + 127) / 2), 23'(r - 64'sd8388608)};
            normal = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] got,
                               input logic [31:0] lo, input logic [31:0] hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got %h, want %h..%h", name, got, lo, hi);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [31:0] ey;
        logic en;
        bit enorm;
        bit done;
        ref_sqrt(x, ey, en, enorm);
        e.x = x;
        e.y = ey;
        e.nv = en;
        e.normal = enorm;
        e.tag = tag;
        in_valid = 1'b1;
        in_x = x;
        in_tag = tag;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got no in_ready, want accept of %h", x);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        real ideal, got;
        if (rstn && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got y=%h tag=%h, want none", out_y, out_tag);
            end else begin
                e = sb.pop_front();
                check("result_y", out_y, e.y);
                check("result_tag", 32'(out_tag), 32'(e.tag));
                check("result_nv", 32'(out_nv), 32'(e.nv));
                if (e.normal) begin
                    // Loose bound against the true square root of the significand.
                    ideal = $sqrt((e.x[23] ? 1.0 : 2.0) * (8388608.0 + real'(e.x[22:0]))
                                  / 8388608.0) * 8388608.0;
                    got = 8388608.0 + real'(out_y[22:0]);
                    n_checks++;
                    if (got - ideal > 8.0 || ideal - got > 8.0) begin
                        n_err++;
                        $display("FAIL sqrt_accuracy: got %h, want near %f for x=%h",
                                 out_y, ideal, e.x);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rand_normal();
        return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    initial begin
        int lat;
        int n0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_y", out_y, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_out_nv", 32'(out_nv), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;

        // 4.0 and 2.0 through an empty pipeline
        send(32'h4080_0000, 4'd1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_edges", 32'(lat), 32'd3);
        check_range("sqrt_4", out_y, 32'h3FFF_FFFE, 32'h4000_0001);
        repeat (3) @(posedge clk);
        #1;
        send(32'h4000_0000, 4'd2);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_range("sqrt_2", out_y, 32'h3FB5_04F1, 32'h3FB5_04F5);
        repeat (3) @(posedge clk);
        #1;

        // Specials back-to-back
        send(32'h0000_0000, 4'd1);
        send(32'h8000_0000, 4'd2);
        send(32'h0000_0001, 4'd3);
        send(32'hBF80_0000, 4'd4);
        send(32'h7F80_0000, 4'd5);
        send(32'h7F80_0001, 4'd6);
        send(32'hFF80_0000, 4'd7);
        send(32'h7FC0_0001, 4'd8);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure mid-stream
        fork
            begin
                for (int k = 0; k < 8; k++) send(rand_normal(), 4'(k));
            end
            begin
                logic [31:0] y0;
                logic [TAG_W-1:0] t0;
                int t;
                t = 0;
                while (!out_valid && t < 50) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                ready_fixed = 1'b0;
                t = 0;
                do begin
                    @(posedge clk);
                    #2;
                    t++;
                end while (!(out_valid && !out_ready) && t < 20);
                check("stall_entered", 32'(out_valid && !out_ready), 32'd1);
                y0 = out_y;
                t0 = out_tag;
                for (int k = 0; k < 5; k++) begin
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_y_stable", out_y, y0);
                    check("stall_tag_stable", 32'(out_tag), 32'(t0));
                    @(posedge clk);
                    #2;
                end
                ready_fixed = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Reset with three operations in flight
        send(rand_normal(), 4'd9);
        send(rand_normal(), 4'd10);
        send(rand_normal(), 4'd11);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_out_y", out_y, 32'd0);
        check("mid_reset_out_tag", 32'(out_tag), 32'd0);
        check("mid_reset_out_nv", 32'(out_nv), 32'd0);
        check("mid_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        n0 = n_out;
        repeat (8) @(posedge clk);
        #1;
        check("no_ghost_results", 32'(n_out - n0), 32'd0);

        // Random sweep with random backpressure and input gaps
        ready_rand = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(($urandom_range(0, 7) == 0) ? 32'($urandom) : rand_normal(), 4'($urandom));
        end
        ready_rand = 1'b0;
        ready_fixed = 1'b1;
        lat = 0;
        while (sb.size() != 0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
